bp_nonsynth_branch_perf_counters: RTL and testbench
===================================================

// Module: bp_nonsynth_branch_perf_counters
// PURPOSE
// - Parametrised branch-prediction event counter bank inside the core, fed by the BE commit and resolve paths.
// - Counts committed instructions (multi-lane), control-flow types, mispredicts and BTB/RAS hits in saturating counters.
// - Cumulative mode: live totals. Windowed mode: snapshot bank captured every window_p committed instructions.
// - All counters are readable through a registered read port (MPKI and hit rates are computed by software).
// PARAMETERS
// - commit_width_p   1     commit lanes per cycle
// - cnt_width_p      32    width of every counter and of rd_data_o
// - window_p         1000  committed instructions per window (>=1); fits in cnt_width_p
// PORTS
// - clk_i              in   1                  clock
// - reset_n_i          in   1                  asynchronous active-low reset
// - en_i               in   1                  counting enable
// - freeze_i           in   1                  pause counting; state is held
// - clear_i            in   1                  zero live+snapshot banks, window count and overflow_o
// - mode_i             in   1                  0 = cumulative, 1 = windowed; latched only in e_off
// - commit_v_i         in   commit_width_p     per-lane instruction commit
// - res_v_i            in   1                  one control-flow resolution this cycle
// - res_type_i         in   2                  0 br, 1 jal, 2 jalr, 3 ret
// - res_mispred_i      in   1                  resolution was a redirect
// - res_src_btb_i      in   1                  prediction came from BTB
// - res_src_ras_i      in   1                  prediction came from RAS
// - rd_v_i             in   1                  read request
// - rd_addr_i          in   4                  counter index
// - rd_v_o             out  1                  read data valid
// - rd_data_o          out  cnt_width_p        read data
// - snap_v_o           out  1                  one-cycle pulse: window closed
// - overflow_o         out  1                  sticky: any counter saturated
// BEHAVIOUR
// - Counter index: 0 instr, 1 br, 2 jal, 3 jalr, 4 ret, 5 mispred_all, 6 mispred_br, 7 btb_hit, 8 ras_hit.
//   Indices 9..15 read as 0.
// - Reset (reset_n_i low, async): all counters 0; state e_off; mode 0; rd_v_o, rd_data_o, snap_v_o, overflow_o 0.
// - FSM states e_off, e_run, e_frz. Transitions:
//   - e_off->e_run on en_i (mode_i latched at this transition).
//   - e_run->e_frz on freeze_i; e_frz->e_run on !freeze_i.
//   - any state->e_off on !en_i.
//   - Counters update only in e_run.
// - e_run update per cycle:
//   - instr += popcount(commit_v_i).
//   - If res_v_i: the counter for res_type_i += 1; mispred_all += res_mispred_i;
//     mispred_br += res_mispred_i & (type==br); btb_hit += res_src_btb_i & !res_mispred_i;
//     ras_hit += res_src_ras_i & !res_mispred_i.
// - Saturation: each add clamps at 2^cnt_width_p-1; any clamp sets overflow_o (sticky until clear_i/reset).
// - Windowed mode:
//   - Window count wc accumulates popcount(commit_v_i).
//   - When wc+popcount >= window_p: all of that cycle's events belong to the closing window.
//   - The next-cycle snapshot bank holds those updated values; live bank and wc become 0; snap_v_o pulses 1 cycle.
//   - Excess lanes beyond window_p are not carried.
// - Read: 1-cycle latency; rd_v_o = rd_v_i delayed by one cycle.
//   - Data comes from the live bank (mode 0) or the snapshot bank (mode 1), sampled at the request cycle.
//   - Reads are accepted in every state; there is no backpressure.
// - clear_i has priority over same-cycle events and over window close (no snap_v_o).
//   - A same-cycle read returns pre-clear values.
// - Reset mid-window: everything zeroed; a pending read is dropped (rd_v_o=0).
// - Mode is fixed while in e_run/e_frz; changes apply only after a pass through e_off.
// TESTING
// - Reset, en_i=1, mode 0, commit_width_p=2, commit_v_i=2'b11 for 10 cycles -> read idx0 returns 20, rd_v_o 1 cycle later.
// - 5 res_v_i br (2 mispred, 3 btb), 1 ret ras-hit -> br=5, mispred_all=2, mispred_br=2, btb_hit=3, ras_hit=1, ret=1.
// - Mode 1, window_p=8, 2 lanes, 4 full cycles -> snap_v_o pulses once; snapshot instr=8, live instr=0; reading idx12 returns 0.
// - cnt_width_p=4: 20 commits -> instr=15, overflow_o=1; clear_i -> all 0, overflow_o=0.
// - freeze_i high 3 cycles with commits -> counts unchanged; clear_i with res_v_i and window close same cycle -> all 0, no snap_v_o.
// - reset_n_i low mid-window with rd_v_i -> all outputs 0 asynchronously; rd_v_o stays 0.

Source files
------------

// File: rtl/bp_nonsynth_branch_perf_counters.sv
// Branch-prediction event counter bank: saturating counters for commits, control-flow
// types, mispredicts and BTB/RAS hits, with cumulative or windowed-snapshot reporting.
module bp_nonsynth_branch_perf_counters #(
    parameter int commit_width_p = 1,
    parameter int cnt_width_p    = 32,
    parameter int window_p       = 1000
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      en_i,
    input  logic                      freeze_i,
    input  logic                      clear_i,
    input  logic                      mode_i,
    input  logic [commit_width_p-1:0] commit_v_i,
    input  logic                      res_v_i,
    input  logic [1:0]                res_type_i,
    input  logic                      res_mispred_i,
    input  logic                      res_src_btb_i,
    input  logic                      res_src_ras_i,
    input  logic                      rd_v_i,
    input  logic [3:0]                rd_addr_i,
    output logic                      rd_v_o,
    output logic [cnt_width_p-1:0]    rd_data_o,
    output logic                      snap_v_o,
    output logic                      overflow_o
);

    localparam int num_cnt_lp = 9;

    typedef enum logic [1:0] {e_off, e_run, e_frz} state_e;
    typedef logic [cnt_width_p-1:0] cnt_t;
    typedef logic [cnt_width_p:0]   wide_t;

    state_e state_r;
    logic   mode_r;
    cnt_t   live_r [num_cnt_lp];
    cnt_t   snap_r [num_cnt_lp];
    cnt_t   wc_r;

    cnt_t   pop;
    cnt_t   inc       [num_cnt_lp];
    cnt_t   next_live [num_cnt_lp];
    logic   sat_any;
    logic   win_close;
    logic   count_en;
    cnt_t   rd_mux;
    wide_t  sum;
    wide_t  wc_sum;

    // Freeze and disable take effect in the same cycle they are raised.
    assign count_en = (state_r == e_run) && en_i && !freeze_i;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        pop       = '0;
        sat_any   = 1'b0;
        sum       = '0;
        for (int i = 0; i < commit_width_p; i++) begin
            pop = pop + cnt_t'(commit_v_i[i]);
        end
        for (int k = 0; k < num_cnt_lp; k++) begin
            inc[k] = '0;
        end
        inc[0] = pop;
        if (res_v_i) begin
            inc[int'(res_type_i) + 1] = cnt_t'(1'b1);
            inc[5] = cnt_t'(res_mispred_i);
            inc[6] = cnt_t'(res_mispred_i && (res_type_i == 2'd0));
            inc[7] = cnt_t'(res_src_btb_i && !res_mispred_i);
            inc[8] = cnt_t'(res_src_ras_i && !res_mispred_i);
        end
        for (int k = 0; k < num_cnt_lp; k++) begin
            sum = {1'b0, live_r[k]} + {1'b0, inc[k]};
            if (sum[cnt_width_p]) begin
                next_live[k] = '1;
                sat_any      = 1'b1;
            end else begin
                next_live[k] = sum[cnt_width_p-1:0];
            end
        end
        wc_sum    = {1'b0, wc_r} + {1'b0, pop};
        win_close = mode_r && (wc_sum >= wide_t'(window_p));
    end

    always_comb begin
        rd_mux = '0;
        if (rd_addr_i < 4'd9) begin
            rd_mux = mode_r ? snap_r[rd_addr_i] : live_r[rd_addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= e_off;
            mode_r     <= 1'b0;
            wc_r       <= '0;
            rd_v_o     <= 1'b0;
            rd_data_o  <= '0;
            snap_v_o   <= 1'b0;
            overflow_o <= 1'b0;
            // NOTE: the counter banks are reset because software may read them right after reset.
            for (int k = 0; k < num_cnt_lp; k++) begin
                live_r[k] <= '0;
                snap_r[k] <= '0;
            end
        end else begin
            if (!en_i) begin
                state_r <= e_off;
            end else begin
                case (state_r)
                    e_off: begin
                        state_r <= e_run;
                        mode_r  <= mode_i;
                    end
                    e_run:   if (freeze_i)  state_r <= e_frz;
                    e_frz:   if (!freeze_i) state_r <= e_run;
                    default: state_r <= e_off;
                endcase
            end

            // Read samples the banks as they stand before this edge's update.
            rd_v_o    <= rd_v_i;
            rd_data_o <= rd_v_i ? rd_mux : '0;
            snap_v_o  <= 1'b0;

            if (clear_i) begin
                wc_r       <= '0;
                overflow_o <= 1'b0;
                for (int k = 0; k < num_cnt_lp; k++) begin
                    live_r[k] <= '0;
                    snap_r[k] <= '0;
                end
            end else if (count_en) begin
                if (sat_any) overflow_o <= 1'b1;
                if (win_close) begin
                    wc_r     <= '0;
                    snap_v_o <= 1'b1;
                    for (int k = 0; k < num_cnt_lp; k++) begin
                        snap_r[k] <= next_live[k];
                        live_r[k] <= '0;
                    end
                end else begin
                    if (mode_r) wc_r <= wc_r + pop;
                    for (int k = 0; k < num_cnt_lp; k++) begin
                        live_r[k] <= next_live[k];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_branch_perf_counters.sv
// Bench for the branch perf counter bank: two instances (wide counters / window 8 and
// 4-bit counters / window 15) share stimulus and are compared every cycle against a model.
module tb_bp_nonsynth_branch_perf_counters;

    logic       clk = 1'b0;
    logic       reset_n, en, freeze, clear, mode, rd_v;
    logic       res_v, res_mis, res_btb, res_ras;
    logic [1:0] commit, res_type;
    logic [3:0] rd_addr;

    logic        rd_v_a, snap_v_a, ovf_a;
    logic [31:0] rd_data_a;
    logic        rd_v_b, snap_v_b, ovf_b;
    logic [3:0]  rd_data_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    always #5 clk = ~clk;

    bp_nonsynth_branch_perf_counters #(.commit_width_p(2), .cnt_width_p(32), .window_p(8)) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .freeze_i(freeze), .clear_i(clear),
        .mode_i(mode), .commit_v_i(commit), .res_v_i(res_v), .res_type_i(res_type),
        .res_mispred_i(res_mis), .res_src_btb_i(res_btb), .res_src_ras_i(res_ras),
        .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_v_o(rd_v_a), .rd_data_o(rd_data_a),
        .snap_v_o(snap_v_a), .overflow_o(ovf_a));

    bp_nonsynth_branch_perf_counters #(.commit_width_p(2), .cnt_width_p(4), .window_p(15)) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .en_i(en), .freeze_i(freeze), .clear_i(clear),
        .mode_i(mode), .commit_v_i(commit), .res_v_i(res_v), .res_type_i(res_type),
        .res_mispred_i(res_mis), .res_src_btb_i(res_btb), .res_src_ras_i(res_ras),
        .rd_v_i(rd_v), .rd_addr_i(rd_addr), .rd_v_o(rd_v_b), .rd_data_o(rd_data_b),
        .snap_v_o(snap_v_b), .overflow_o(ovf_b));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_live [2][9];
    longint m_snap [2][9];
    longint m_wc   [2];
    bit     m_ovf  [2];
    bit     m_snapv[2];
    longint m_rd   [2];
    bit     m_rdv, m_on, m_paused, m_mode;

    function automatic longint max_of(int d);
        return (d == 0) ? 64'h0000_0000_FFFF_FFFF : 64'd15;
    endfunction

    function automatic longint win_of(int d);
        return (d == 0) ? 64'd8 : 64'd15;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        longint ev [9];
        longint nxt[9];
        longint s;
        bit     counting;
        if (!reset_n) begin
            m_rdv = 0; m_on = 0; m_paused = 0; m_mode = 0;
            for (int d = 0; d < 2; d++) begin
                m_wc[d] = 0; m_ovf[d] = 0; m_snapv[d] = 0; m_rd[d] = 0;
                for (int k = 0; k < 9; k++) begin
                    m_live[d][k] = 0;
                    m_snap[d][k] = 0;
                end
            end
        end else begin
            counting = m_on && !m_paused && en && !freeze;
            m_rdv = rd_v;
            for (int k = 0; k < 9; k++) ev[k] = 0;
            ev[0] = $countones(commit);
            if (res_v) begin
                ev[int'(res_type) + 1] = 1;
                ev[5] = longint'(res_mis);
                ev[6] = longint'(res_mis && res_type == 2'd0);
                ev[7] = longint'(res_btb && !res_mis);
                ev[8] = longint'(res_ras && !res_mis);
            end
            for (int d = 0; d < 2; d++) begin
                m_rd[d] = 0;
                if (rd_v && rd_addr < 9) m_rd[d] = m_mode ? m_snap[d][rd_addr] : m_live[d][rd_addr];
                m_snapv[d] = 0;
                if (clear) begin
                    m_wc[d] = 0; m_ovf[d] = 0;
                    for (int k = 0; k < 9; k++) begin
                        m_live[d][k] = 0;
                        m_snap[d][k] = 0;
                    end
                end else if (counting) begin
                    for (int k = 0; k < 9; k++) begin
                        s = m_live[d][k] + ev[k];
                        if (s > max_of(d)) begin
                            s = max_of(d);
                            m_ovf[d] = 1;
                        end
                        nxt[k] = s;
                    end
                    if (m_mode && (m_wc[d] + ev[0] >= win_of(d))) begin
                        for (int k = 0; k < 9; k++) begin
                            m_snap[d][k] = nxt[k];
                            m_live[d][k] = 0;
                        end
                        m_wc[d]    = 0;
                        m_snapv[d] = 1;
                    end else begin
                        for (int k = 0; k < 9; k++) m_live[d][k] = nxt[k];
                        if (m_mode) m_wc[d] = m_wc[d] + ev[0];
                    end
                end
            end
            if (!en) begin
                m_on = 0;
            end else if (!m_on) begin
                m_on = 1; m_paused = 0; m_mode = mode;
            end else begin
                m_paused = freeze;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            check("a.rd_v",     64'(rd_v_a),    64'(m_rdv));
            check("a.rd_data",  64'(rd_data_a), 64'(m_rd[0]));
            check("a.snap_v",   64'(snap_v_a),  64'(m_snapv[0]));
            check("a.overflow", 64'(ovf_a),     64'(m_ovf[0]));
            check("b.rd_v",     64'(rd_v_b),    64'(m_rdv));
            check("b.rd_data",  64'(rd_data_b), 64'(m_rd[1]));
            check("b.snap_v",   64'(snap_v_b),  64'(m_snapv[1]));
            check("b.overflow", 64'(ovf_b),     64'(m_ovf[1]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle_inputs();
        commit = 2'b00; res_v = 0; res_type = 2'd0; res_mis = 0; res_btb = 0; res_ras = 0;
        rd_v = 0; rd_addr = 4'd0; clear = 0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read(input logic [3:0] addr);
        rd_v = 1; rd_addr = addr;
        @(negedge clk);
        rd_v = 0;
    endtask

    task automatic resolve(input logic [1:0] t, input logic mis, input logic btb, input logic ras);
        res_v = 1; res_type = t; res_mis = mis; res_btb = btb; res_ras = ras;
        @(negedge clk);
        res_v = 0; res_mis = 0; res_btb = 0; res_ras = 0;
    endtask

    initial begin : stim
        int snaps;
        idle_inputs();
        en = 0; freeze = 0; mode = 0; reset_n = 1;
        #2 reset_n = 0;
        cycles(2);
        check("reset.rd_v",     64'(rd_v_a),    64'd0);
        check("reset.rd_data",  64'(rd_data_a), 64'd0);
        check("reset.snap_v",   64'(snap_v_a),  64'd0);
        check("reset.overflow", 64'(ovf_a),     64'd0);
        reset_n = 1;
        cmp_on  = 1;

        // cumulative commits, both lanes, 10 cycles
        en = 1;
        cycles(1);
        commit = 2'b11;
        cycles(10);
        commit = 2'b00;
        read(4'd0);
        check("instr20.a",   64'(rd_data_a), 64'd20);
        check("instr20.rdv", 64'(rd_v_a),    64'd1);
        check("instr_sat.b", 64'(rd_data_b), 64'd15);
        check("ovf_set.b",   64'(ovf_b),     64'd1);
        check("ovf_clr.a",   64'(ovf_a),     64'd0);
        cycles(1);
        check("rdv_one_cycle", 64'(rd_v_a), 64'd0);

        clear = 1; cycles(1); clear = 0;
        check("ovf_after_clear.b", 64'(ovf_b), 64'd0);
        read(4'd0);
        check("instr_after_clear.b", 64'(rd_data_b), 64'd0);

        // resolutions: first br is a mispredicted BTB hit and must not count as btb_hit
        resolve(2'd0, 1, 1, 0);
        resolve(2'd0, 1, 0, 0);
        resolve(2'd0, 0, 1, 0);
        resolve(2'd0, 0, 1, 0);
        resolve(2'd0, 0, 1, 0);
        resolve(2'd3, 0, 0, 1);
        read(4'd1); check("br",          64'(rd_data_a), 64'd5);
        read(4'd2); check("jal",         64'(rd_data_a), 64'd0);
        read(4'd4); check("ret",         64'(rd_data_a), 64'd1);
        read(4'd5); check("mispred_all", 64'(rd_data_a), 64'd2);
        read(4'd6); check("mispred_br",  64'(rd_data_a), 64'd2);
        read(4'd7); check("btb_hit",     64'(rd_data_a), 64'd3);
        read(4'd8); check("ras_hit",     64'(rd_data_a), 64'd1);

        // freeze holds counts
        commit = 2'b11; cycles(1);
        freeze = 1; cycles(3);
        freeze = 0; commit = 2'b00; cycles(1);
        read(4'd0);
        check("freeze_hold", 64'(rd_data_a), 64'd2);

        // windowed mode via a pass through e_off
        en = 0; cycles(1);
        mode = 1; en = 1; cycles(1);
        clear = 1; cycles(1); clear = 0;
        snaps = 0;
        commit = 2'b11;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            snaps += int'(snap_v_a);
        end
        commit = 2'b00;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            snaps += int'(snap_v_a);
        end
        check("snap_pulses", 64'(snaps), 64'd1);
        read(4'd0);
        check("snap_instr.a", 64'(rd_data_a), 64'd8);
        check("snap_instr.b", 64'(rd_data_b), 64'd0);
        read(4'd12);
        check("idx12", 64'(rd_data_a), 64'd0);

        // second window: snapshot is 8 again only if the live bank restarted at 0
        commit = 2'b11; cycles(4); commit = 2'b00;
        read(4'd0);
        check("snap2_instr.a", 64'(rd_data_a), 64'd8);
        check("snap2_instr.b", 64'(rd_data_b), 64'd15);

        // clear coincident with a resolution and a window close
        commit = 2'b11; cycles(3);
        res_v = 1; res_type = 2'd0; clear = 1;
        cycles(1);
        idle_inputs();
        check("clear_no_snap", 64'(snap_v_a), 64'd0);
        read(4'd0); check("clear_instr", 64'(rd_data_a), 64'd0);
        read(4'd1); check("clear_br",    64'(rd_data_a), 64'd0);

        // asynchronous reset mid-window with a read in flight
        read(4'd0);
        commit = 2'b11; cycles(2);
        rd_v = 1; rd_addr = 4'd0;
        #2 reset_n = 0;
        #1;
        check("async.rd_v",     64'(rd_v_a),    64'd0);
        check("async.rd_data",  64'(rd_data_a), 64'd0);
        check("async.snap_v",   64'(snap_v_a),  64'd0);
        check("async.overflow", 64'(ovf_b),     64'd0);
        @(negedge clk);
        reset_n = 1;
        idle_inputs();
        @(negedge clk);
        check("read_dropped", 64'(rd_v_a), 64'd0);

        cycles(2);
        cmp_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
